mem_stage_lsu: RTL
==================

# mem_stage_lsu

Memory-stage load/store unit between the execute stage and writeback. Accepts one instruction per handshake from execute and issues byte/half/word accesses to a single-port data memory over a req/ready bus. It sign/zero-extends load data and delivers a registered writeback bundle (ALUResult, FinalDataMemoryRead, PC4, A3, RegW, ResultSelect). It stalls the upstream pipeline while a memory access is outstanding.

## Interface
- DMEM_TIMEOUT, 16: max cycles in REQ without dmem_ready before bus error (≥1, counter width $clog2(DMEM_TIMEOUT+1))
- clk  in  1  sole clock, all state on rising edge
- reset  in  1  synchronous, active-high
- in_valid  in  1  execute bundle present
- in_ready  out  1  stage can accept (state IDLE); in_stall = ~in_ready to hazard unit
- in_alu_result  in  32  ALUResult / effective address
- in_rd2  in  32  store data
- in_funct3  in  3  load type (Load_Type_Case) or store type (Store_Type_Case)
- in_memw  in  1  store
- in_memr  in  1  load (ResultSelect == RESULT_MEM)
- in_a3  in  5  destination register
- in_regw  in  1  register write enable
- in_result_select  in  2  Result_Mux_Case
- in_pc4  in  32  PC+4
- dmem_req  out  1  access request, held until dmem_ready
- dmem_we  out  1  write
- dmem_addr  out  32  word-aligned address ({addr[31:2],2'b00})
- dmem_wdata  out  32  lane-replicated store data
- dmem_be  out  4  byte enables
- dmem_ready  in  1  access complete; dmem_rdata valid same cycle
- dmem_rdata  in  32  read word
- wb_valid  out  1  writeback bundle valid, one cycle per accepted instruction
- wb_alu_result, wb_final_read, wb_pc4  out  32 each  to writeback mux
- wb_a3  out  5;  wb_regw  out  1;  wb_result_select  out  2
- wb_misaligned  out  1  access misaligned, suppressed
- wb_bus_err  out  1  access timed out

## Operation
- States: IDLE, REQ. Accept = in_valid & in_ready.
- IDLE, accept, neither memw nor memr: register bundle; next cycle wb_valid=1, stay IDLE.
- IDLE, accept, memory op, aligned: latch address/data/be/funct3, go REQ.
- Misalignment: half with addr[0]=1; word with addr[1:0]≠0. No request; next cycle wb_valid=1, wb_misaligned=1, wb_regw=0; stay IDLE.
- memw and memr both set: treat as store.
- Store lanes: SB be=1<<addr[1:0], wdata={4{rd2[7:0]}}; SH be=addr[1]?1100:0011, wdata={2{rd2[15:0]}}; SW be=1111, wdata=rd2.
- Loads: dmem_be=1111, dmem_we=0; selected byte/half chosen by addr[1:0], LB/LH sign-extended, LBU/LHU zero-extended, LW unchanged. Unlisted funct3 values are treated as LW/SW.
- REQ: dmem_req=1 with all dmem_* stable; on dmem_ready → wb_valid next cycle with extended data (stores: wb_final_read=0), return IDLE.
- Timeout: counter clears on entering REQ, increments each REQ cycle without ready; reaching DMEM_TIMEOUT → drop req, wb_valid next cycle with wb_bus_err=1, wb_regw=0, IDLE.
- dmem_ready outside REQ is ignored.

## Timing
- Reset: state IDLE, in_ready=1, dmem_req/we=0, dmem_addr/wdata/be=0, all wb_* 0, wb_result_select=RESULT_ALU, counter 0.
- Non-memory latency: accept cycle N → wb_valid at N+1.
- Memory: accept N, dmem_req from N+1; ready at M≥N+1 → wb_valid at M+1, in_ready at M+1 (back-to-back accept allowed at M+1).
- Zero-wait memory (ready at N+1): 2-cycle latency, in_ready low for exactly 1 cycle.
- Reset mid-REQ: dmem_req drops next cycle, in-flight op discarded, no wb_valid.
- All outputs registered; no combinational path from dmem_ready to wb_*. in_ready depends on state only.

## Structure
- Pkg gains Store_Type_Case (SB=000, SH=001, SW=010) and Lsu_State_Case (IDLE, REQ); reuses Load_Type_Case, Result_Mux_Case. Output bundle matches Memory_Bundle fields.
- Sub-module load_extend: combinational lane select plus sign/zero extension (rdata, addr[1:0], Load_Type_Case → 32-bit).

## Test plan
- ALU op, alu_result=0x1234, regw=1, a3=5 → wb_valid at N+1, wb_alu_result=0x1234, no dmem_req.
- SB addr=0x103, rd2=0xAB, ready at once → dmem_be=1000, dmem_addr=0x100, wdata=0xABABABAB.
- LB addr=0x102, rdata=0x0080FF00 with 3-cycle ready delay → in_ready low 3 cycles, wb_final_read=0xFFFFFF80; LBU same → 0x00000080.
- LH addr=0x101 → no dmem_req, wb_misaligned=1, wb_regw=0 at N+1.
- LW, dmem_ready never asserted, DMEM_TIMEOUT=4 → req for 4 cycles, then wb_bus_err=1, wb_regw=0.
- Reset asserted during REQ → dmem_req=0 next cycle, no wb_valid, in_ready=1.

Source files
------------

// File: rtl/mem_stage_lsu_pkg.sv
// Shared types and helpers for the memory-stage load/store unit.
package mem_stage_lsu_pkg;

    // Load width/sign selection, carried in funct3 for loads.
    typedef enum logic [2:0] {
        LB  = 3'b000,
        LH  = 3'b001,
        LW  = 3'b010,
        LBU = 3'b100,
        LHU = 3'b101
    } Load_Type_Case;

    // Store width selection, carried in funct3 for stores.
    typedef enum logic [2:0] {
        SB = 3'b000,
        SH = 3'b001,
        SW = 3'b010
    } Store_Type_Case;

    // Writeback result mux selection.
    typedef enum logic [1:0] {
        RESULT_ALU = 2'b00,
        RESULT_MEM = 2'b01,
        RESULT_PC4 = 2'b10
    } Result_Mux_Case;

    // LSU control states.
    typedef enum logic {
        IDLE = 1'b0,
        REQ  = 1'b1
    } Lsu_State_Case;

    localparam logic [1:0] SIZE_B = 2'd0;
    localparam logic [1:0] SIZE_H = 2'd1;
    localparam logic [1:0] SIZE_W = 2'd2;

    // Access width; funct3 codes without a byte/half meaning fall back to word.
    function automatic logic [1:0] access_size(input logic is_store, input logic [2:0] f3);
        logic [1:0] size;
        if (is_store) begin
            case (f3)
                SB:      size = SIZE_B;
                SH:      size = SIZE_H;
                default: size = SIZE_W;
            endcase
        end else begin
            case (f3)
                LB, LBU: size = SIZE_B;
                LH, LHU: size = SIZE_H;
                default: size = SIZE_W;
            endcase
        end
        return size;
    endfunction

    // Halves need an even address, words need a 4-byte aligned address.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] addr_lo);
        logic mis;
        if (size == SIZE_H) begin
            mis = addr_lo[0];
        end else if (size == SIZE_W) begin
            mis = (addr_lo != 2'b00);
        end else begin
            mis = 1'b0;
        end
        return mis;
    endfunction

endpackage

// File: rtl/mem_stage_lsu_load_extend.sv
// Selects the addressed byte/half of a read word and sign/zero-extends it.
module mem_stage_lsu_load_extend
    import mem_stage_lsu_pkg::*;
(
    input  logic [31:0] rdata_i,
    input  logic [1:0]  addr_lo_i,
    input  logic [2:0]  funct3_i,
    output logic [31:0] data_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;

    // Lane selection followed by extension according to the load type.
    always_comb begin
        byte_s = 8'h00;
        half_s = 16'h0000;
        data_o = rdata_i;
        case (addr_lo_i)
            2'b00:   byte_s = rdata_i[7:0];
            2'b01:   byte_s = rdata_i[15:8];
            2'b10:   byte_s = rdata_i[23:16];
            2'b11:   byte_s = rdata_i[31:24];
            default: byte_s = rdata_i[7:0];
        endcase
        if (addr_lo_i[1]) begin
            half_s = rdata_i[31:16];
        end else begin
            half_s = rdata_i[15:0];
        end
        case (funct3_i)
            LB:      data_o = {{24{byte_s[7]}}, byte_s};
            LBU:     data_o = {24'h000000, byte_s};
            LH:      data_o = {{16{half_s[15]}}, half_s};
            LHU:     data_o = {16'h0000, half_s};
            default: data_o = rdata_i;
        endcase
    end

endmodule

// File: rtl/mem_stage_lsu.sv
// Memory-stage load/store unit: accepts one execute bundle at a time, runs the
// data-memory access over a req/ready bus and emits a registered writeback bundle.
module mem_stage_lsu
    import mem_stage_lsu_pkg::*;
#(
    parameter int DMEM_TIMEOUT = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_alu_result,
    input  logic [31:0] in_rd2,
    input  logic [2:0]  in_funct3,
    input  logic        in_memw,
    input  logic        in_memr,
    input  logic [4:0]  in_a3,
    input  logic        in_regw,
    input  logic [1:0]  in_result_select,
    input  logic [31:0] in_pc4,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic [31:0] dmem_rdata,
    output logic        wb_valid,
    output logic [31:0] wb_alu_result,
    output logic [31:0] wb_final_read,
    output logic [31:0] wb_pc4,
    output logic [4:0]  wb_a3,
    output logic        wb_regw,
    output logic [1:0]  wb_result_select,
    output logic        wb_misaligned,
    output logic        wb_bus_err
);

    localparam int CW = $clog2(DMEM_TIMEOUT + 1);
    localparam logic [CW-1:0] CTR_LAST = CW'(DMEM_TIMEOUT - 1);

    Lsu_State_Case state_q;
    logic [CW-1:0] ctr_q;

    logic        dmem_req_q;
    logic        dmem_we_q;
    logic [31:0] dmem_addr_q;
    logic [31:0] dmem_wdata_q;
    logic [3:0]  dmem_be_q;

    // Bundle of the access in flight, released to writeback when it completes.
    logic [31:0] pend_alu_q;
    logic [31:0] pend_pc4_q;
    logic [4:0]  pend_a3_q;
    logic        pend_regw_q;
    logic [1:0]  pend_rs_q;
    logic [2:0]  pend_funct3_q;
    logic        pend_store_q;

    logic        wb_valid_q;
    logic [31:0] wb_alu_result_q;
    logic [31:0] wb_final_read_q;
    logic [31:0] wb_pc4_q;
    logic [4:0]  wb_a3_q;
    logic        wb_regw_q;
    logic [1:0]  wb_result_select_q;
    logic        wb_misaligned_q;
    logic        wb_bus_err_q;

    logic        is_mem_s;
    logic [1:0]  size_s;
    logic        misaligned_s;
    logic [3:0]  be_s;
    logic [31:0] wdata_s;
    logic [31:0] ext_s;

    mem_stage_lsu_load_extend u_load_extend (
        .rdata_i   (dmem_rdata),
        .addr_lo_i (pend_alu_q[1:0]),
        .funct3_i  (pend_funct3_q),
        .data_o    (ext_s)
    );

    // Decode the incoming bundle: width, alignment, byte enables and lane-replicated data.
    always_comb begin
        is_mem_s     = in_memw | in_memr;
        size_s       = access_size(in_memw, in_funct3);
        misaligned_s = is_misaligned(size_s, in_alu_result[1:0]);
        be_s         = 4'b1111;
        wdata_s      = 32'h0000_0000;
        if (in_memw) begin
            if (size_s == SIZE_B) begin
                be_s    = 4'b0001 << in_alu_result[1:0];
                wdata_s = {4{in_rd2[7:0]}};
            end else if (size_s == SIZE_H) begin
                be_s    = in_alu_result[1] ? 4'b1100 : 4'b0011;
                wdata_s = {2{in_rd2[15:0]}};
            end else begin
                be_s    = 4'b1111;
                wdata_s = in_rd2;
            end
        end else begin
            be_s    = 4'b1111;
            wdata_s = 32'h0000_0000;
        end
    end

    // Control FSM with all bus and writeback outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q            <= IDLE;
            ctr_q              <= '0;
            dmem_req_q         <= 1'b0;
            dmem_we_q          <= 1'b0;
            dmem_addr_q        <= 32'h0000_0000;
            dmem_wdata_q       <= 32'h0000_0000;
            dmem_be_q          <= 4'b0000;
            pend_alu_q         <= 32'h0000_0000;
            pend_pc4_q         <= 32'h0000_0000;
            pend_a3_q          <= 5'd0;
            pend_regw_q        <= 1'b0;
            pend_rs_q          <= RESULT_ALU;
            pend_funct3_q      <= 3'b000;
            pend_store_q       <= 1'b0;
            wb_valid_q         <= 1'b0;
            wb_alu_result_q    <= 32'h0000_0000;
            wb_final_read_q    <= 32'h0000_0000;
            wb_pc4_q           <= 32'h0000_0000;
            wb_a3_q            <= 5'd0;
            wb_regw_q          <= 1'b0;
            wb_result_select_q <= RESULT_ALU;
            wb_misaligned_q    <= 1'b0;
            wb_bus_err_q       <= 1'b0;
        end else begin
            wb_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (in_valid) begin
                        if (!is_mem_s || misaligned_s) begin
                            // Completes without touching memory; misaligned ops are suppressed.
                            wb_valid_q         <= 1'b1;
                            wb_alu_result_q    <= in_alu_result;
                            wb_final_read_q    <= 32'h0000_0000;
                            wb_pc4_q           <= in_pc4;
                            wb_a3_q            <= in_a3;
                            wb_regw_q          <= in_regw & ~is_mem_s;
                            wb_result_select_q <= in_result_select;
                            wb_misaligned_q    <= is_mem_s;
                            wb_bus_err_q       <= 1'b0;
                        end else begin
                            state_q       <= REQ;
                            ctr_q         <= '0;
                            dmem_req_q    <= 1'b1;
                            dmem_we_q     <= in_memw;
                            dmem_addr_q   <= {in_alu_result[31:2], 2'b00};
                            dmem_wdata_q  <= wdata_s;
                            dmem_be_q     <= be_s;
                            pend_alu_q    <= in_alu_result;
                            pend_pc4_q    <= in_pc4;
                            pend_a3_q     <= in_a3;
                            pend_regw_q   <= in_regw;
                            pend_rs_q     <= in_result_select;
                            pend_funct3_q <= in_funct3;
                            pend_store_q  <= in_memw;
                        end
                    end else begin
                        state_q <= IDLE;
                    end
                end
                REQ: begin
                    if (dmem_ready || (ctr_q == CTR_LAST)) begin
                        // Access done or timed out: drop the request and release the bundle.
                        state_q            <= IDLE;
                        dmem_req_q         <= 1'b0;
                        dmem_we_q          <= 1'b0;
                        wb_valid_q         <= 1'b1;
                        wb_alu_result_q    <= pend_alu_q;
                        wb_pc4_q           <= pend_pc4_q;
                        wb_a3_q            <= pend_a3_q;
                        wb_result_select_q <= pend_rs_q;
                        wb_misaligned_q    <= 1'b0;
                        wb_bus_err_q       <= ~dmem_ready;
                        wb_regw_q          <= pend_regw_q & dmem_ready;
                        if (dmem_ready && !pend_store_q) begin
                            wb_final_read_q <= ext_s;
                        end else begin
                            wb_final_read_q <= 32'h0000_0000;
                        end
                    end else begin
                        ctr_q <= ctr_q + CW'(1);
                    end
                end
                default: begin
                    state_q    <= IDLE;
                    dmem_req_q <= 1'b0;
                    dmem_we_q  <= 1'b0;
                end
            endcase
        end
    end

    assign in_ready         = (state_q == IDLE);
    assign dmem_req         = dmem_req_q;
    assign dmem_we          = dmem_we_q;
    assign dmem_addr        = dmem_addr_q;
    assign dmem_wdata       = dmem_wdata_q;
    assign dmem_be          = dmem_be_q;
    assign wb_valid         = wb_valid_q;
    assign wb_alu_result    = wb_alu_result_q;
    assign wb_final_read    = wb_final_read_q;
    assign wb_pc4           = wb_pc4_q;
    assign wb_a3            = wb_a3_q;
    assign wb_regw          = wb_regw_q;
    assign wb_result_select = wb_result_select_q;
    assign wb_misaligned    = wb_misaligned_q;
    assign wb_bus_err       = wb_bus_err_q;

endmodule
